// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: NEWGAME/PLAY/NEWBALL/OVER FSM, ball count, pause timer, BCD score.
// Optional score counter built only when PONG_BCD_SCORE_EN is defined; all outputs registered.
module pong_game_ctrl #(
    parameter int NUM_BALLS   = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_reset,
    output logic [1:0] balls_left,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] BALLS_INIT = NUM_BALLS[1:0];
    localparam logic [7:0] TIMER_INIT = TIMER_TICKS[7:0];

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] balls_q, balls_d;
    logic       gra_still_q, ball_reset_q, ball_reset_d;
    logic       score_inc, score_clr;
    logic       pressed;

    assign pressed = |btn;

    always_comb begin
        state_d      = state_q;
        balls_d      = balls_q;
        ball_reset_d = 1'b0;
        score_inc    = 1'b0;
        score_clr    = 1'b0;
        timer_d      = (refr_tick && timer_q != 8'd0) ? timer_q - 8'd1 : timer_q;
        case (state_q)
            NEWGAME: begin
                balls_d   = BALLS_INIT;
                score_clr = 1'b1;
                if (pressed) begin
                    state_d      = PLAY;
                    ball_reset_d = 1'b1;
                end
            end
            PLAY: begin
                // miss takes priority: a simultaneous hit is dropped
                if (miss) begin
                    timer_d = TIMER_INIT;
                    if (balls_q <= 2'd1) begin
                        balls_d = 2'd0;
                        state_d = OVER;
                    end else begin
                        balls_d = balls_q - 2'd1;
                        state_d = NEWBALL;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            NEWBALL: begin
                if (timer_q == 8'd0 && pressed) begin
                    state_d      = PLAY;
                    ball_reset_d = 1'b1;
                end
            end
            OVER: begin
                if (timer_q == 8'd0) begin
                    state_d   = NEWGAME;
                    balls_d   = BALLS_INIT;
                    score_clr = 1'b1;
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= NEWGAME;
            timer_q      <= 8'd0;
            balls_q      <= BALLS_INIT;
            gra_still_q  <= 1'b1;
            ball_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            balls_q      <= balls_d;
            gra_still_q  <= (state_d != PLAY);
            ball_reset_q <= ball_reset_d;
        end
    end

    assign gra_still  = gra_still_q;
    assign ball_reset = ball_reset_q;
    assign balls_left = balls_q;
    assign game_state = state_q;

`ifdef PONG_BCD_SCORE_EN
    logic [3:0] d1_q, d0_q, d1_d, d0_d;

    always_comb begin
        d1_d = d1_q;
        d0_d = d0_q;
        if (score_clr) begin
            d1_d = 4'd0;
            d0_d = 4'd0;
        end else if (score_inc) begin
            if (d0_q == 4'd9) begin
                d0_d = 4'd0;
                d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
            end else begin
                d0_d = d0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_q <= 4'd0;
            d0_q <= 4'd0;
        end else begin
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    assign score_d1 = d1_q;
    assign score_d0 = d0_q;
`else
    logic unused_score;
    assign unused_score = score_inc | score_clr;
    assign score_d1     = 4'd0;
    assign score_d0     = 4'd0;
`endif
endmodule
